// File: rtl/pipeline_ctrl_if.sv
// Control bundle between the rv32i datapath and pipeline_ctrl.
// master: datapath side (drives requests, consumes enables/valids).
// slave:  pipeline_ctrl (consumes requests, drives enables/valids).
interface pipeline_ctrl_if;
   logic stall_i;
   logic flush_i;
   logic dmem_ready_i;
   logic pc_en_o;
   logic ifid_en_o;
   logic ifid_flush_o;
   logic idex_en_o;
   logic idex_flush_o;
   logic exmem_en_o;
   logic memwb_en_o;
   logic valid_id_o;
   logic valid_ex_o;
   logic valid_mem_o;
   logic valid_wb_o;
   logic retire_o;

   modport master (
      output stall_i,
      output flush_i,
      output dmem_ready_i,
      input  pc_en_o,
      input  ifid_en_o,
      input  ifid_flush_o,
      input  idex_en_o,
      input  idex_flush_o,
      input  exmem_en_o,
      input  memwb_en_o,
      input  valid_id_o,
      input  valid_ex_o,
      input  valid_mem_o,
      input  valid_wb_o,
      input  retire_o
   );

   modport slave (
      input  stall_i,
      input  flush_i,
      input  dmem_ready_i,
      output pc_en_o,
      output ifid_en_o,
      output ifid_flush_o,
      output idex_en_o,
      output idex_flush_o,
      output exmem_en_o,
      output memwb_en_o,
      output valid_id_o,
      output valid_ex_o,
      output valid_mem_o,
      output valid_wb_o,
      output retire_o
   );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline control for the 5-stage rv32i core: turns load-use stall,
// EX redirect and dmem wait into per-stage enables/bubbles, tracks
// per-stage valid bits and reports retirement.
// Ports: clk, rst (async, active-high); ctrl (pipeline_ctrl_if.slave)
// with requests in and enables/flushes/valids/retire out;
// cyc/ret/stall/flush counters (CNT_W bits each).
// Optional: PIPE_CTRL_PERF_CNT_EN builds the performance counters;
// without it the four counter outputs are tied to 0.
module pipeline_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   pipeline_ctrl_if.slave   ctrl,
   output logic [CNT_W-1:0] cyc_cnt_o,
   output logic [CNT_W-1:0] ret_cnt_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   typedef enum logic [1:0] {
      M_RUN,
      M_STALL,
      M_FLUSH,
      M_FREEZE
   } mode_e;

   mode_e mode;

   logic v_id_q, v_id_d;
   logic v_ex_q, v_ex_d;
   logic v_mem_q, v_mem_d;
   logic v_wb_q, v_wb_d;

   // A stall needs both the dependent (ID) and the load (EX) to be
   // real; a flush needs a real branch in EX.
   logic stall_qual;
   logic flush_qual;

   assign stall_qual = ctrl.stall_i & v_id_q & v_ex_q;
   assign flush_qual = ctrl.flush_i & v_ex_q;

   always_comb begin
      mode = M_RUN;
      if (!ctrl.dmem_ready_i) begin
         mode = M_FREEZE;
      end else if (flush_qual) begin
         mode = M_FLUSH;
      end else if (stall_qual) begin
         mode = M_STALL;
      end
   end

   always_comb begin
      ctrl.pc_en_o      = 1'b1;
      ctrl.ifid_en_o    = 1'b1;
      ctrl.ifid_flush_o = 1'b0;
      ctrl.idex_en_o    = 1'b1;
      ctrl.idex_flush_o = 1'b0;
      ctrl.exmem_en_o   = 1'b1;
      ctrl.memwb_en_o   = 1'b1;
      v_id_d  = 1'b1;
      v_ex_d  = v_id_q;
      v_mem_d = v_ex_q;
      v_wb_d  = v_mem_q;
      unique case (mode)
         M_RUN: begin
         end
         M_STALL: begin
            ctrl.pc_en_o      = 1'b0;
            ctrl.ifid_en_o    = 1'b0;
            ctrl.idex_flush_o = 1'b1;
            v_id_d = v_id_q;
            v_ex_d = 1'b0;
         end
         M_FLUSH: begin
            ctrl.ifid_flush_o = 1'b1;
            ctrl.idex_flush_o = 1'b1;
            v_id_d = 1'b0;
            v_ex_d = 1'b0;
         end
         M_FREEZE: begin
            ctrl.pc_en_o    = 1'b0;
            ctrl.ifid_en_o  = 1'b0;
            ctrl.idex_en_o  = 1'b0;
            ctrl.exmem_en_o = 1'b0;
            ctrl.memwb_en_o = 1'b0;
            v_id_d  = v_id_q;
            v_ex_d  = v_ex_q;
            v_mem_d = v_mem_q;
            v_wb_d  = v_wb_q;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_id_q  <= 1'b0;
         v_ex_q  <= 1'b0;
         v_mem_q <= 1'b0;
         v_wb_q  <= 1'b0;
      end else begin
         v_id_q  <= v_id_d;
         v_ex_q  <= v_ex_d;
         v_mem_q <= v_mem_d;
         v_wb_q  <= v_wb_d;
      end
   end

   assign ctrl.valid_id_o  = v_id_q;
   assign ctrl.valid_ex_o  = v_ex_q;
   assign ctrl.valid_mem_o = v_mem_q;
   assign ctrl.valid_wb_o  = v_wb_q;
   // dmem_ready gates retire so a frozen WB is not counted twice.
   assign ctrl.retire_o    = v_wb_q & ctrl.dmem_ready_i;

`ifdef PIPE_CTRL_PERF_CNT_EN
   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
   logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      cyc_cnt_d   = cyc_cnt_q + ONE;
      ret_cnt_d   = ret_cnt_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (ctrl.retire_o) begin
         ret_cnt_d = ret_cnt_q + ONE;
      end
      if (mode == M_STALL) begin
         stall_cnt_d = stall_cnt_q + ONE;
      end
      if (mode == M_FLUSH) begin
         flush_cnt_d = flush_cnt_q + ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc_cnt_q   <= '0;
         ret_cnt_q   <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         cyc_cnt_q   <= cyc_cnt_d;
         ret_cnt_q   <= ret_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign cyc_cnt_o   = cyc_cnt_q;
   assign ret_cnt_o   = ret_cnt_q;
   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;
`else
   assign cyc_cnt_o   = '0;
   assign ret_cnt_o   = '0;
   assign stall_cnt_o = '0;
   assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl.
// Counter expectations collapse to 0 when PIPE_CTRL_PERF_CNT_EN is off.
module tb_pipeline_ctrl;

`ifdef PIPE_CTRL_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic [31:0] cyc_cnt;
   logic [31:0] ret_cnt;
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;
   int          tests;
   int          fails;

   pipeline_ctrl_if bus ();

   pipeline_ctrl #(.CNT_W(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .ctrl        (bus.slave),
      .cyc_cnt_o   (cyc_cnt),
      .ret_cnt_o   (ret_cnt),
      .stall_cnt_o (stall_cnt),
      .flush_cnt_o (flush_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] cx(input int n);
      return PERF ? 32'(n) : 32'd0;
   endfunction

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_v(input string tag, input logic [3:0] exp);
      chk(tag, {bus.valid_id_o, bus.valid_ex_o,
                bus.valid_mem_o, bus.valid_wb_o}, 32'(exp));
   endtask

   // Order: pc, ifid_en, ifid_fl, idex_en, idex_fl, exmem, memwb
   task automatic chk_en(input string tag, input logic [6:0] exp);
      chk(tag, {bus.pc_en_o, bus.ifid_en_o, bus.ifid_flush_o,
                bus.idex_en_o, bus.idex_flush_o,
                bus.exmem_en_o, bus.memwb_en_o}, 32'(exp));
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst = 1'b1;
      bus.stall_i = 1'b0;
      bus.flush_i = 1'b0;
      bus.dmem_ready_i = 1'b1;

      // Reset state
      tick();
      tick();
      chk_v("rst_valids", 4'b0000);
      chk("rst_retire", bus.retire_o, 0);
      chk("rst_cyc", cyc_cnt, 0);
      chk_en("rst_en_run", 7'b1101011);
      rst = 1'b0;

      // Fill: E1..E6
      #1;
      chk_v("fill_e0", 4'b0000);
      tick();
      chk_v("fill_e1", 4'b1000);
      chk("cyc_e1", cyc_cnt, cx(1));
      tick();
      chk_v("fill_e2", 4'b1100);
      tick();
      chk_v("fill_e3", 4'b1110);
      chk("ret_e3", bus.retire_o, 0);
      tick();
      chk_v("fill_e4", 4'b1111);
      chk("ret_e4", bus.retire_o, 1);
      chk("retcnt_e4", ret_cnt, cx(0));
      tick();
      tick();
      chk("retcnt_e6", ret_cnt, cx(2));
      chk("cyc_e6", cyc_cnt, cx(6));

      // Single load-use stall
      bus.stall_i = 1'b1;
      #1;
      chk_en("stall_en", 7'b0001111);
      tick();
      bus.stall_i = 1'b0;
      chk_v("stall_e7", 4'b1011);
      chk("stallcnt_e7", stall_cnt, cx(1));
      chk_en("post_stall_run", 7'b1101011);
      tick();
      chk_v("stall_e8", 4'b1101);
      chk("ret_e8", bus.retire_o, 1);
      tick();
      chk_v("stall_e9", 4'b1110);
      chk("ret_e9_gap", bus.retire_o, 0);
      tick();
      chk_v("stall_e10", 4'b1111);
      chk("ret_e10", bus.retire_o, 1);
      chk("retcnt_e10", ret_cnt, cx(5));

      // Flush with simultaneous stall: flush wins
      bus.flush_i = 1'b1;
      bus.stall_i = 1'b1;
      #1;
      chk_en("flush_en", 7'b1111111);
      tick();
      bus.flush_i = 1'b0;
      bus.stall_i = 1'b0;
      chk_v("flush_e11", 4'b0011);
      chk("flushcnt_e11", flush_cnt, cx(1));
      chk("stallcnt_e11", stall_cnt, cx(1));
      chk("retcnt_e11", ret_cnt, cx(6));
      // Flush with v_ex=0 is ignored
      bus.flush_i = 1'b1;
      #1;
      chk_en("flush_noex", 7'b1101011);
      bus.flush_i = 1'b0;
      tick();
      tick();
      tick();
      tick();
      chk_v("refill_e15", 4'b1111);
      chk("retcnt_e15", ret_cnt, cx(8));
      chk("flushcnt_e15", flush_cnt, cx(1));

      // Freeze 3 cycles with stall held
      bus.dmem_ready_i = 1'b0;
      bus.stall_i = 1'b1;
      #1;
      chk_en("frz_en", 7'b0000000);
      chk("frz_ret", bus.retire_o, 0);
      tick();
      tick();
      tick();
      chk_v("frz_valids", 4'b1111);
      chk("frz_cyc", cyc_cnt, cx(18));
      chk("frz_stallcnt", stall_cnt, cx(1));
      chk("frz_retcnt", ret_cnt, cx(8));
      bus.dmem_ready_i = 1'b1;
      #1;
      chk_en("unfrz_stall", 7'b0001111);
      chk("unfrz_ret", bus.retire_o, 1);
      tick();
      bus.stall_i = 1'b0;
      chk_v("unfrz_e19", 4'b1011);
      chk("unfrz_stallcnt", stall_cnt, cx(2));
      chk("unfrz_retcnt", ret_cnt, cx(9));
      chk_en("unfrz_run", 7'b1101011);
      tick();

      // Async reset in the middle of a stall cycle
      bus.stall_i = 1'b1;
      #1;
      chk_en("pre_rst_stall", 7'b0001111);
      #1;
      rst = 1'b1;
      #1;
      chk_v("arst_valids", 4'b0000);
      chk("arst_ret", bus.retire_o, 0);
      chk("arst_cyc", cyc_cnt, 0);
      chk("arst_retcnt", ret_cnt, 0);
      chk("arst_stallcnt", stall_cnt, 0);
      tick();
      rst = 1'b0;
      // stall_i still high but v_ex=0: treated as RUN
      #1;
      chk_en("stall_empty", 7'b1101011);
      tick();
      bus.stall_i = 1'b0;
      chk_v("rerun_e1", 4'b1000);
      chk("rerun_cyc", cyc_cnt, cx(1));
      chk("rerun_stallcnt", stall_cnt, cx(0));
      tick();
      tick();
      tick();
      chk_v("rerun_e4", 4'b1111);
      chk("rerun_ret", bus.retire_o, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Consumer of the load-use `stall` from Hazard_Detection and of branch/jump redirect and data-memory wait.
- Turns these into per-stage register enables and bubble inserts, and tracks a valid bit per pipeline stage (ID, EX, MEM, WB).
- Sits beside the 5-stage rv32i datapath and gates the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Reports retirement and optional performance counters.

Parameters:
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- stall_i  in  1  load-use stall request from Hazard_Detection
- flush_i  in  1  taken branch/jump resolved in EX
- dmem_ready_i  in  1  data memory ready; 0 freezes the whole pipeline
- pc_en_o  out  1  PC register load enable
- ifid_en_o  out  1  IF/ID register enable
- ifid_flush_o  out  1  IF/ID gets a bubble this edge
- idex_en_o  out  1  ID/EX register enable
- idex_flush_o  out  1  ID/EX gets a bubble this edge
- exmem_en_o  out  1  EX/MEM enable
- memwb_en_o  out  1  MEM/WB enable
- valid_id_o  out  1  ID-stage valid
- valid_ex_o  out  1  EX-stage valid; gates flush/stall qualification
- valid_mem_o  out  1  MEM-stage valid; gates dmem write
- valid_wb_o  out  1  WB-stage valid; gates regfile write
- retire_o  out  1  one instruction retires this cycle
- cyc_cnt_o  out  CNT_W  cycle counter
- ret_cnt_o  out  CNT_W  retired-instruction counter
- stall_cnt_o  out  CNT_W  load-use stall cycles
- flush_cnt_o  out  CNT_W  flush events

Behaviour:
- Clock and reset are fixed: one clock `clk`; reset `rst` is asynchronous and active-high.
- State consists of four valid flops: v_id, v_ex, v_mem, v_wb. Reset clears all of them to 0.
- Qualified requests:
  - stall_q = stall_i & v_id & v_ex
  - flush_q = flush_i & v_ex
- Mode priority, highest first: FREEZE (dmem_ready_i=0) > FLUSH (flush_q) > STALL (stall_q) > RUN.
- FREEZE:
  - All enables 0 and both flush outputs 0.
  - Valid flops hold; retire_o=0.
  - stall_i and flush_i are ignored. The requester holds them, and they are re-evaluated when dmem_ready_i returns.
- FLUSH:
  - pc_en_o=1 (PC loads the redirect target); ifid_en_o=1 with ifid_flush_o=1; idex_en_o=1 with idex_flush_o=1; exmem_en_o=memwb_en_o=1.
  - Next state: v_id<=0, v_ex<=0, v_mem<=v_ex, v_wb<=v_mem.
  - A simultaneous stall_i is discarded because the dependent ID instruction is killed.
- STALL:
  - pc_en_o=0, ifid_en_o=0 (IF/ID holds).
  - idex_en_o=1 with idex_flush_o=1 (bubble); exmem_en_o=memwb_en_o=1.
  - Next state: v_id holds, v_ex<=0, v_mem<=v_ex, v_wb<=v_mem.
  - Exactly one bubble per load-use. The next cycle the load is in MEM, so Hazard_Detection deasserts.
- RUN:
  - All enables 1, flush outputs 0.
  - Next state: v_id<=1, v_ex<=v_id, v_mem<=v_ex, v_wb<=v_mem.
- Output timing:
  - Enables and flush outputs are combinational from the current mode.
  - Valid outputs are direct flop outputs.
  - retire_o = v_wb & dmem_ready_i.
- After reset release the first RUN edge sets v_id. The first instruction reaches WB on the 4th RUN edge, so retire_o first goes high in the cycle after the 4th RUN edge.
- Outputs while rst=1:
  - All valids 0 and retire_o 0; all counters 0.
  - Enables still follow the mode, which is harmless because the datapath registers are also in reset.
- Reset asserted mid-stall or mid-freeze drops all in-flight state immediately, with no pending bubble carried over.
- stall_i or flush_i while the qualifying valid is 0 has no effect and is treated as RUN.

Optional Feature:
- Macro: PIPE_CTRL_PERF_CNT_EN.
- Defined:
  - cyc_cnt_o increments every cycle out of reset.
  - ret_cnt_o increments on retire_o.
  - stall_cnt_o increments in STALL cycles.
  - flush_cnt_o increments in FLUSH cycles.
  - All counters are CNT_W bits, wrap modulo 2^CNT_W, and are cleared by rst.
  - FREEZE cycles count only in cyc_cnt_o.
- Undefined:
  - No counter flops are instantiated.
  - All four counter outputs are tied to 0.

Test Plan:
- Reset then RUN for 6 cycles with stall_i=0, flush_i=0, dmem_ready_i=1:
  - valid_id_o rises after edge 1, valid_wb_o after edge 4.
  - retire_o=1 from the cycle after edge 4 onward.
  - ret_cnt_o=2 after edge 6.
- Pipeline full, stall_i=1 for one cycle:
  - That cycle: pc_en_o=0, ifid_en_o=0, idex_flush_o=1.
  - Next cycle valid_ex_o=0; three cycles later retire_o=0 for exactly one cycle.
  - stall_cnt_o=1.
- Pipeline full, flush_i=1 together with stall_i=1:
  - FLUSH wins: pc_en_o=1, ifid_flush_o=1, idex_flush_o=1.
  - Next cycle valid_id_o=0 and valid_ex_o=0; flush_cnt_o=1, stall_cnt_o=0.
- Pipeline full, dmem_ready_i=0 for 3 cycles with stall_i=1 held:
  - All enables 0, valids unchanged, retire_o=0.
  - cyc_cnt_o still +3.
  - On ready return, exactly one STALL cycle follows.
- stall_i=1 right after reset (valid_ex_o=0):
  - No stall: pc_en_o=1, idex_flush_o=0.
- Assert rst during a STALL cycle:
  - All valids and counters become 0 immediately (asynchronous).
  - After release, behaves as the first-cycle RUN scenario.
